// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter and its picker.
// Requester indices name the writeback sources wired to the arbiter inputs.
package regfile_wr_arbiter_pkg;

  localparam int N_REQ_DEF = 3;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_CP0  = 2;

  // Next round-robin start position after granting requester i.
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit scanning ptr, ptr+1, ... mod N.
// Zero latency; produces one-hot grant, its index, and an any-valid flag.
module regfile_wr_arbiter_rr_pick
  import regfile_wr_arbiter_pkg::*;
#(
  parameter  int N  = N_REQ_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin share of the register-file write port; grant registered into we/rw/w one cycle later.
// Backpressure via req_ready (one-hot or zero); no grants while hold or rst is high.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int AW    = AW_DEF,
  parameter  int DW    = DW_DEF,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_rw,
  input  logic [N_REQ*DW-1:0] req_w,
  output logic [N_REQ-1:0]    req_ready,
  output logic                we,
  output logic [AW-1:0]       rw,
  output logic [DW-1:0]       w,
  output logic [31:0]         wr_count
);

  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    idx;
  logic             any;
  logic             take;
  logic [AW-1:0]    sel_rw;
  logic [DW-1:0]    sel_w;
  logic             sel_nz;

  regfile_wr_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  assign take      = any & ~hold;
  assign req_ready = (rst | hold) ? '0 : grant;
  assign sel_rw    = req_rw[int'(idx)*AW +: AW];
  assign sel_w     = req_w[int'(idx)*DW +: DW];
  // Register 0 still takes its grant slot but must never reach the file.
  assign sel_nz    = (sel_rw != AW'(REG_ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we       <= 1'b0;
      rw       <= '0;
      w        <= '0;
      ptr      <= '0;
      wr_count <= '0;
    end else begin
      we <= 1'b0;
      if (take) begin
        we  <= sel_nz;
        rw  <= sel_rw;
        w   <= sel_w;
        ptr <= IW'(wrap_inc(int'(idx), N_REQ));
        if (sel_nz) wr_count <= wr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed plus randomized bench for regfile_wr_arbiter with a register file
// fed from the write port and a distance-based round-robin reference model.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_rw;
  logic [N*DW-1:0]   req_w;
  logic [N-1:0]      req_ready;
  logic              we;
  logic [AW-1:0]     rw;
  logic [DW-1:0]     w;
  logic [31:0]       wr_count;

  regfile_wr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_w     (req_w),
    .req_ready (req_ready),
    .we        (we),
    .rw        (rw),
    .w         (w),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  // Register file driven by the arbiter's write port; register 0 reads as zero.
  logic [DW-1:0] rf [32] = '{default: '0};
  always @(posedge clk) if (we && rw != '0) rf[rw] <= w;

  // Reference state
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_rw;
  logic [DW-1:0] m_w;
  logic [31:0]   m_cnt;
  logic [DW-1:0] rf_exp [32];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  task automatic chk_rf(input string tag, input int a);
    chk(tag, rf[a], rf_exp[a]);
  endtask

  // Winner is the valid requester at the smallest rotational distance from ptr.
  function automatic int pick(input logic [N-1:0] v, input int p);
    int g = -1;
    int best = N;
    for (int i = 0; i < N; i++) begin
      int d = (i - p + N) % N;
      if (v[i] && d < best) begin
        best = d;
        g    = i;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rw[i*AW +: AW] = a;
    req_w[i*DW +: DW]  = d;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_we  = 1'b0;
    m_rw  = '0;
    m_w   = '0;
    m_cnt = '0;
  endtask

  // One clock: check req_ready mid-cycle, advance the model at the edge, check outputs after it.
  task automatic step(input string tag);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = hold ? -1 : pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_we && m_rw != '0) rf_exp[m_rw] = m_w;
    m_we = 1'b0;
    if (g >= 0) begin
      m_rw  = req_rw[g*AW +: AW];
      m_w   = req_w[g*DW +: DW];
      m_we  = (m_rw != '0);
      if (m_we) m_cnt = m_cnt + 32'd1;
      m_ptr = (g + 1) % N;
    end
    #1;
    chk({tag, ".we"}, 32'(we), 32'(m_we));
    chk({tag, ".rw"}, 32'(rw), 32'(m_rw));
    chk({tag, ".w"}, w, m_w);
    chk({tag, ".cnt"}, wr_count, m_cnt);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_exp[i] = '0;
    model_reset();
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '1;
    req_rw    = '0;
    req_w     = '0;
    set_req(REQ_ALU, 5'd1, 32'hA);
    set_req(REQ_LOAD, 5'd2, 32'hB);
    set_req(REQ_CP0, 5'd3, 32'hC);

    // Reset with all requesters valid
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.rw", 32'(rw), 32'd0);
    chk("rst.w", w, 32'd0);
    chk("rst.cnt", wr_count, 32'd0);
    rst = 1'b0;

    // Round-robin across all three
    for (int i = 0; i < 6; i++) begin
      step("rr");
      chk("rr.seq", 32'(rw), 32'((i % 3) + 1));
    end
    chk("rr.cnt6", wr_count, 32'd6);

    // Register-0 write from the load unit
    req_valid = 3'b010;
    set_req(REQ_LOAD, 5'd0, 32'hFFFF_FFFF);
    step("r0");
    req_valid = '0;
    step("r0.idle");
    chk("r0.cnt", wr_count, 32'd6);
    chk("r0.rf0", rf[0], 32'd0);

    // Hold after a grant to requester 0
    set_req(REQ_LOAD, 5'd2, 32'hB);
    req_valid = 3'b001;
    step("hold.pre");
    req_valid = 3'b111;
    hold = 1'b1;
    repeat (3) step("hold");
    hold = 1'b0;
    step("hold.rel");
    chk("hold.rel.rw", 32'(rw), 32'd2);

    // End-to-end write of register 7 from the coprocessor path
    req_valid = 3'b100;
    set_req(REQ_CP0, 5'd7, 32'h1234_5678);
    step("e2e");
    chk("e2e.pre", rf[7], 32'd0);
    req_valid = '0;
    step("e2e.idle");
    chk("e2e.post", rf[7], 32'h1234_5678);

    // Async reset between the grant edge and the register-file edge
    req_valid = 3'b001;
    set_req(REQ_ALU, 5'd7, 32'hDEAD_BEEF);
    step("ar");
    #2;
    rst = 1'b1;
    #1;
    chk("ar.we", 32'(we), 32'd0);
    chk("ar.ready", 32'(req_ready), 32'd0);
    chk("ar.cnt", wr_count, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("ar.rf7", rf[7], 32'h1234_5678);
    rst = 1'b0;
    req_valid = 3'b111;
    set_req(REQ_ALU, 5'd1, 32'hA);
    step("ar.after");
    chk("ar.ptr0", 32'(rw), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      req_valid = N'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom), $urandom);
      step("rnd");
      chk_rf("rnd.rf", $urandom_range(0, 31));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
